// File: rtl/ysyx_23060221_pkg.sv
// Shared definitions for the ysyx_23060221 load/store unit: memop (funct3)
// encodings, the LSU state enum and the alignment helper.
package ysyx_23060221_pkg;

  // funct3 encodings of the RV32 load/store width field
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // LSU control states: idle, bus request outstanding, awaiting response,
  // result presented to write-back
  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } LsuState;

  // A halfword must sit on an even byte, a word on a word boundary; bytes
  // can never be misaligned. Unknown widths fall back to word rules.
  function automatic logic isMisaligned(input logic [2:0] memop, input logic [1:0] offset);
    logic misaligned;
    misaligned = 1'b0;
    case (memop)
      LS_B, LS_BU: misaligned = 1'b0;
      LS_H, LS_HU: misaligned = offset[0];
      default:     misaligned = (offset != 2'b00);
    endcase
    return misaligned;
  endfunction

endpackage

// File: rtl/ysyx_23060221_lsu_align.sv
// Byte-lane alignment for the LSU: builds store strobes and lane-replicated
// store data, and extracts/extends load data from the returned bus word.
// Purely combinational; the address offset comes from the captured exres.
module ysyx_23060221_lsu_align
  import ysyx_23060221_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Store path: replicate the stored byte/halfword into every lane and
  // enable only the lanes addressed; a misaligned halfword keeps the upper
  // pair of lanes, so one byte is lost rather than wrapped
  always_comb begin
    o_wdata = i_wdata;
    o_wstrb = 4'b1111;
    case (i_memop[1:0])
      2'b00: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = 4'b0001 << i_offset;
      end
      2'b01: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = 4'b0011 << {i_offset[1], 1'b0};
      end
      default: begin
        o_wdata = i_wdata;
        o_wstrb = 4'b1111;
      end
    endcase
  end

  // Load path, step one: low 16 bits of rdata shifted right by 8*offset;
  // offset 3 has only one real byte left, the rest shifts in as zero
  always_comb begin
    w_half = i_rdata[15:0];
    case (i_offset)
      2'd0: w_half = i_rdata[15:0];
      2'd1: w_half = i_rdata[23:8];
      2'd2: w_half = i_rdata[31:16];
      2'd3: w_half = {8'h00, i_rdata[31:24]};
      default: w_half = i_rdata[15:0];
    endcase
    w_byte = w_half[7:0];
  end

  // Load path, step two: sign or zero extension by width; words are not
  // shifted at all, so a misaligned word returns the aligned word as-is
  always_comb begin
    o_rdata = i_rdata;
    case (i_memop)
      LS_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      LS_BU:   o_rdata = {24'h000000, w_byte};
      LS_H:    o_rdata = {{16{w_half[15]}}, w_half};
      LS_HU:   o_rdata = {16'h0000, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060221_lsu.sv
// NPC load/store unit. Consumes instructions from the execute stage on a
// valid/ready handshake, performs memory accesses over a req/gnt/rvalid bus
// and hands each result to write-back on a second valid/ready handshake.
// Optional feature macro: YSYX_23060221_LSU_ALIGN_CHECK_EN -- when defined,
// misaligned halfword/word accesses are not issued and report lsu_fault.
module ysyx_23060221_lsu
  import ysyx_23060221_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        EXU_valid,
  output logic        LSU_ready,
  input  logic [31:0] exres,
  input  logic [31:0] wdata,
  input  logic [2:0]  memop,
  input  logic        memren,
  input  logic        memwen,
  output logic        LSU_valid,
  input  logic        WBU_ready,
  output logic [31:0] lsres,
  output logic        lsu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  LsuState     r_state;
  LsuState     w_nextState;
  LsuState     w_acceptState;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_memop;
  logic        r_ren;
  logic        r_wen;
  logic [31:0] r_lsres;
  logic        r_fault;

  logic        w_accept;
  logic        w_isMem;
  logic        w_misaligned;
  logic        w_inReq;
  logic [31:0] w_laneData;
  logic [3:0]  w_laneStrb;
  logic [31:0] w_loadData;

  // A finished result can be retired and replaced in the same cycle, which
  // keeps back-to-back throughput at one instruction per cycle
  assign LSU_ready = (r_state == LSU_IDLE) | ((r_state == LSU_DONE) & WBU_ready);
  assign w_accept  = EXU_valid & LSU_ready;
  assign w_isMem   = memren | memwen;

`ifdef YSYX_23060221_LSU_ALIGN_CHECK_EN
  assign w_misaligned = w_isMem & isMisaligned(memop, exres[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // Faulting accesses skip the bus entirely and complete straight away
  assign w_acceptState = (w_isMem & ~w_misaligned) ? LSU_REQ : LSU_DONE;

  // State register, synchronous reset abandons any bus transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; gnt is only honoured in REQ and rvalid only in WAIT
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) w_nextState = w_acceptState;
      end
      LSU_REQ: begin
        if (mem_gnt) w_nextState = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (mem_rvalid) w_nextState = LSU_DONE;
      end
      LSU_DONE: begin
        if (w_accept) begin
          w_nextState = w_acceptState;
        end else if (WBU_ready) begin
          w_nextState = LSU_IDLE;
        end
      end
      default: w_nextState = LSU_IDLE;
    endcase
  end

  // Instruction capture on accept and result capture on the bus response;
  // stores report their address as the result, like a passthrough op
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_memop <= 3'b000;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_lsres <= 32'h0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= exres;
      r_wdata <= wdata;
      r_memop <= memop;
      r_ren   <= memren;
      r_wen   <= memwen;
      r_lsres <= w_isMem ? 32'h0 : exres;
      r_fault <= w_misaligned;
    end else if ((r_state == LSU_WAIT) && mem_rvalid) begin
      r_lsres <= r_ren ? w_loadData : r_addr;
    end
  end

  ysyx_23060221_lsu_align u_align (
    .i_memop  (r_memop),
    .i_offset (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_rdata),
    .o_wdata  (w_laneData),
    .o_wstrb  (w_laneStrb),
    .o_rdata  (w_loadData)
  );

  // Bus fields come only from captured registers, so they cannot move
  // while a request is waiting for its grant
  assign w_inReq   = (r_state == LSU_REQ);
  assign mem_req   = w_inReq;
  assign mem_we    = w_inReq & r_wen;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = w_laneData;
  assign mem_wstrb = (w_inReq & r_wen) ? w_laneStrb : 4'b0000;

  assign LSU_valid = (r_state == LSU_DONE);
  assign lsres     = r_lsres;
  assign lsu_fault = r_fault & LSU_valid;

endmodule

// File: tb/tb_ysyx_23060221_lsu.sv
// Scoreboard bench for ysyx_23060221_lsu: directed stimulus pushes expected
// bus requests and write-back results into queues, a monitor pops and
// compares them whenever the DUT issues a granted request or a result.
module tb_ysyx_23060221_lsu;
  import ysyx_23060221_pkg::*;

  logic        clk;
  logic        rst;
  logic        EXU_valid;
  logic        LSU_ready;
  logic [31:0] exres;
  logic [31:0] wdata;
  logic [2:0]  memop;
  logic        memren;
  logic        memwen;
  logic        LSU_valid;
  logic        WBU_ready;
  logic [31:0] lsres;
  logic        lsu_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } BusExp;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        fault;
  } ResExp;

  BusExp busQ[$];
  ResExp resQ[$];
  BusExp monBus;
  ResExp monRes;

  int total = 0;
  int bad   = 0;
  int resId = 0;

  int          gntDelay    = 0;
  int          reqCycles   = 0;
  logic        respPending = 1'b0;
  logic        respDisable = 1'b0;
  logic        strayRvalid = 1'b0;
  logic [31:0] busRdata    = 32'h0;

  ysyx_23060221_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .EXU_valid  (EXU_valid),
    .LSU_ready  (LSU_ready),
    .exres      (exres),
    .wdata      (wdata),
    .memop      (memop),
    .memren     (memren),
    .memwen     (memwen),
    .LSU_valid  (LSU_valid),
    .WBU_ready  (WBU_ready),
    .lsres      (lsres),
    .lsu_fault  (lsu_fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Bus slave model: grants after gntDelay request cycles, responds one
  // cycle after the grant, and can inject a stray rvalid on demand
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid  = (respPending && !respDisable) || strayRvalid;
      respPending = 1'b0;
      mem_rdata   = busRdata;
      if (mem_req) begin
        mem_gnt = (reqCycles >= gntDelay);
        reqCycles++;
      end else begin
        mem_gnt   = 1'b0;
        reqCycles = 0;
      end
    end
  end

  // Monitor: compares every granted bus request and every retired result
  // against the head of the matching scoreboard queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_req && mem_gnt) begin
        respPending = 1'b1;
        if (busQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedBus: request to 0x%08h issued, none expected", mem_addr);
        end else begin
          monBus = busQ.pop_front();
          checkOutput("busWe", mem_we, monBus.we);
          checkOutput("busAddr", mem_addr, monBus.addr);
          checkOutput("busStrb", mem_wstrb, monBus.wstrb);
          if (monBus.we) checkOutput("busWdata", mem_wdata, monBus.wdata);
        end
      end
      if (!rst && LSU_valid && WBU_ready) begin
        if (resQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedResult: lsres 0x%08h presented, none expected", lsres);
        end else begin
          monRes = resQ.pop_front();
          checkOutput($sformatf("lsres#%0d", monRes.id), lsres, monRes.res);
          checkOutput($sformatf("fault#%0d", monRes.id), lsu_fault, monRes.fault);
        end
      end
    end
  end

  // Present one instruction and hold it until the LSU accepts it; returns
  // how many cycles the handshake took
  task automatic applyStimulus(input logic [31:0] ex, input logic [31:0] wd, input logic [2:0] op,
                               input logic ren, input logic wen, input logic pushRes,
                               input logic [31:0] expRes, input logic expFault, output int waits);
    logic acc;
    if (pushRes) begin
      resQ.push_back('{id: resId, res: expRes, fault: expFault});
      resId++;
    end
    EXU_valid = 1'b1;
    exres     = ex;
    wdata     = wd;
    memop     = op;
    memren    = ren;
    memwen    = wen;
    waits     = 0;
    acc       = 1'b0;
    do begin
      @(negedge clk);
      acc = LSU_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!acc && waits < 50);
    checkOutput("acceptHandshake", acc, 1'b1);
    EXU_valid = 1'b0;
    memren    = 1'b0;
    memwen    = 1'b0;
  endtask

  // Count cycles from accept until LSU_valid, bounded
  task automatic waitValid(input int expLat, input string name);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!LSU_valid && cnt < 40);
    checkOutput(name, cnt, expLat);
    @(posedge clk);
    #1;
  endtask

  task automatic doLoad(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] rd,
                        input logic [31:0] expAddr, input logic [31:0] expRes, input string name);
    int waits;
    busRdata = rd;
    busQ.push_back('{we: 1'b0, addr: expAddr, wdata: 32'h0, wstrb: 4'b0000});
    applyStimulus(addr, 32'h0, op, 1'b1, 1'b0, 1'b1, expRes, 1'b0, waits);
    waitValid(3, name);
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] wd,
                         input logic [31:0] expAddr, input logic [3:0] expStrb,
                         input logic [31:0] expWdata, input string name);
    int waits;
    busQ.push_back('{we: 1'b1, addr: expAddr, wdata: expWdata, wstrb: expStrb});
    applyStimulus(addr, wd, op, 1'b0, 1'b1, 1'b1, addr, 1'b0, waits);
    waitValid(3, name);
  endtask

  // Directed test sequence
  initial begin
    int waits;
    int cnt;
    rst       = 1'b1;
    EXU_valid = 1'b0;
    exres     = 32'h0;
    wdata     = 32'h0;
    memop     = 3'b000;
    memren    = 1'b0;
    memwen    = 1'b0;
    WBU_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rstValid", LSU_valid, 1'b0);
    checkOutput("rstReq", mem_req, 1'b0);
    checkOutput("rstWe", mem_we, 1'b0);
    checkOutput("rstStrb", mem_wstrb, 4'b0000);
    checkOutput("rstLsres", lsres, 32'h0);
    checkOutput("rstFault", lsu_fault, 1'b0);
    checkOutput("rstReady", LSU_ready, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] passthrough op");
    applyStimulus(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b0, waits);
    @(negedge clk);
    checkOutput("passValidN1", LSU_valid, 1'b1);
    checkOutput("passNoReq", mem_req, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("passBackIdle", LSU_valid, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] stores");
    doStore(32'h8000_0003, LS_B, 32'h0000_00AB, 32'h8000_0000, 4'b1000, 32'hABAB_ABAB, "sbLatency");
    doStore(32'h4000_0002, LS_H, 32'h1234_BEEF, 32'h4000_0000, 4'b1100, 32'hBEEF_BEEF, "shLatency");
    doStore(32'h4000_0010, LS_W, 32'hDEAD_BEEF, 32'h4000_0010, 4'b1111, 32'hDEAD_BEEF, "swLatency");

    $display("[TB] loads");
    doLoad(32'h1000_0002, LS_B,  32'h00F0_0000, 32'h1000_0000, 32'hFFFF_FFF0, "lbLatency");
    doLoad(32'h1000_0002, LS_BU, 32'h00F0_0000, 32'h1000_0000, 32'h0000_00F0, "lbuLatency");
    doLoad(32'h5000_0001, LS_B,  32'h1122_8344, 32'h5000_0000, 32'hFFFF_FF83, "lbOff1");
    doLoad(32'h5000_0003, LS_BU, 32'h7F00_0000, 32'h5000_0000, 32'h0000_007F, "lbuOff3");
    doLoad(32'h2000_0006, LS_HU, 32'h8765_4321, 32'h2000_0004, 32'h0000_8765, "lhuLatency");
    doLoad(32'h4000_0010, LS_W,  32'hCAFE_F00D, 32'h4000_0010, 32'hCAFE_F00D, "lwLatency");

    $display("[TB] delayed grant");
    gntDelay = 3;
    busRdata = 32'h8765_4321;
    busQ.push_back('{we: 1'b0, addr: 32'h2000_0004, wdata: 32'h0, wstrb: 4'b0000});
    applyStimulus(32'h2000_0006, 32'h0, LS_H, 1'b1, 1'b0, 1'b1, 32'hFFFF_8765, 1'b0, waits);
    cnt = 0;
    do begin
      @(negedge clk);
      if (mem_req) begin
        cnt++;
        checkOutput("reqAddrStable", mem_addr, 32'h2000_0004);
      end
    end while (mem_req && cnt < 20);
    checkOutput("reqCycles", cnt, 4);
    @(posedge clk);
    #1;
    waitValid(1, "lhAfterWait");
    @(negedge clk);
    checkOutput("noSecondReq", mem_req, 1'b0);
    gntDelay = 0;
    @(posedge clk);
    #1;

    $display("[TB] write-back backpressure");
    WBU_ready = 1'b0;
    applyStimulus(32'h0000_55AA, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_55AA, 1'b0, waits);
    waitValid(1, "bpValid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpHoldValid", LSU_valid, 1'b1);
      checkOutput("bpHoldLsres", lsres, 32'h0000_55AA);
      checkOutput("bpNotReady", LSU_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    WBU_ready = 1'b1;
    applyStimulus(32'h0000_0077, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 1'b0, waits);
    checkOutput("sameCycleAccept", waits, 1);
    waitValid(1, "b2bValid");

`ifdef YSYX_23060221_LSU_ALIGN_CHECK_EN
    $display("[TB] misaligned accesses trapped");
    applyStimulus(32'h3000_0001, 32'h0, LS_W, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, waits);
    @(negedge clk);
    checkOutput("lwMisNoReq", mem_req, 1'b0);
    checkOutput("lwMisValid", LSU_valid, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(32'h3000_0001, 32'h0000_CAFE, LS_H, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, waits);
    waitValid(1, "shMisValid");
    doStore(32'h3000_0003, LS_B, 32'h0000_005A, 32'h3000_0000, 4'b1000, 32'h5A5A_5A5A, "sbNeverMis");
`else
    $display("[TB] misaligned accesses issued");
    doLoad(32'h3000_0001, LS_W, 32'hAABB_CCDD, 32'h3000_0000, 32'hAABB_CCDD, "lwMis");
    doLoad(32'h3000_0003, LS_H, 32'h9A00_0000, 32'h3000_0000, 32'h0000_009A, "lhMis");
    doStore(32'h3000_0003, LS_H, 32'h0000_CAFE, 32'h3000_0000, 4'b1100, 32'hCAFE_CAFE, "shMis");
    doStore(32'h3000_0002, LS_W, 32'h0102_0304, 32'h3000_0000, 4'b1111, 32'h0102_0304, "swMis");
`endif

    $display("[TB] reset during REQ");
    gntDelay = 50;
    applyStimulus(32'h6000_0000, 32'h0, LS_W, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, waits);
    @(negedge clk);
    checkOutput("reqBeforeRst", mem_req, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reqRstDropReq", mem_req, 1'b0);
    checkOutput("reqRstReady", LSU_ready, 1'b1);
    gntDelay = 0;
    @(posedge clk);
    #1;

    $display("[TB] reset during WAIT");
    respDisable = 1'b1;
    busQ.push_back('{we: 1'b0, addr: 32'h6000_0000, wdata: 32'h0, wstrb: 4'b0000});
    applyStimulus(32'h6000_0000, 32'h0, LS_W, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, waits);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("inWaitNotReady", LSU_ready, 1'b0);
    checkOutput("inWaitNoReq", mem_req, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("waitRstReady", LSU_ready, 1'b1);
    checkOutput("waitRstNoReq", mem_req, 1'b0);
    strayRvalid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    strayRvalid = 1'b0;
    checkOutput("strayIgnored", LSU_valid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("strayStillIdle", LSU_valid, 1'b0);
    respDisable = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("resQEmpty", resQ.size(), 0);
    checkOutput("busQEmpty", busQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
